mc_line_responder: RTL and testbench
====================================

Name: mc_line_responder

Overview:
- Memory-controller end of the cache line-fill/writeback interface (mc_req/mc_read/mc_ack/mc_paddr/mc_fill_line/mc_writeback_line/mc_writeback_mask).
- Accepts one 128-bit line request from the cache and converts it into 32-bit word beats on a wait-stated backing memory port.
- Returns a one-cycle mc_ack pulse when done; for reads, the assembled fill line is presented alongside the ack.

Parameters:
- TIMEOUT, 255: max cycles a single beat may wait for mem_ready before abort; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mc_req  in  1  cache request, level, held until ack
- mc_read  in  1  1 = line fill, 0 = writeback; valid with mc_req
- mc_paddr  in  26  byte address; bits [25:4] select the line, [3:0] ignored
- mc_writeback_line  in  128  writeback data; word i at [32i+31:32i]
- mc_writeback_mask  in  4  bit i = write word i
- mc_ack  out  1  one-cycle completion pulse
- mc_fill_line  out  128  fill data; valid from ack cycle until next read completes
- mc_err  out  1  one-cycle pulse coincident with mc_ack on timeout abort
- busy  out  1  high whenever state != IDLE
- mem_en  out  1  beat request to backing memory
- mem_we  out  1  beat is a write
- mem_addr  out  24  word address = {line[25:4], beat[1:0]}
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid when mem_ready=1
- mem_ready  in  1  beat completes at the edge where mem_en & mem_ready

Behaviour:
- Reset (async, rst_n=0), all outputs registered:
  - mc_ack=0, mc_err=0, mc_fill_line=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; state=IDLE; beat and timeout counters cleared.
  - Reset mid-burst abandons the request with no ack; any partial write already issued stays in memory.
- States: IDLE, BEAT, ACK.
- IDLE:
  - When mc_req=1, latch mc_read, mc_paddr[25:4], mc_writeback_line and mc_writeback_mask. Inputs are not re-sampled until the next IDLE.
  - Read: beat=0, go to BEAT.
  - Write: beat = lowest set mask bit, go to BEAT. A write with mask=0 goes directly to ACK with no beats.
- BEAT:
  - mem_en=1; mem_we = ~latched_read; mem_addr = {line, beat}; mem_wdata = latched word[beat].
  - On an edge with mem_ready=1:
    - Read: capture mem_rdata into the shadow line at word[beat].
    - Advance to the next beat: reads visit every beat 0..3; writes visit only the set mask bits, in ascending order.
    - After the last beat: mem_en drops and the state goes to ACK.
  - Back-to-back beats: mem_en stays high across beats; addr and wdata update on the ready edge.
- Timeout:
  - Counter resets on each beat start; increments each BEAT cycle with mem_ready=0.
  - When it reaches TIMEOUT, abort to ACK with err flag set. Read abort fills the missing words with 0.
- ACK (exactly one cycle):
  - mc_ack=1. For reads, mc_fill_line is loaded from the shadow on entry, so it is valid in this same cycle. mc_err=1 if aborted.
  - Then return to IDLE.
- Handshake rule:
  - The requester must drop mc_req at the edge where it samples mc_ack=1. The responder re-samples mc_req in IDLE no earlier than two edges after the ack was registered, so no request is double-serviced.
  - mc_req high again in that IDLE cycle is a new request.
- Latency with mem_ready tied to 1:
  - Read: 4 BEAT cycles + 1 ACK = ack 5 cycles after the accepting edge.
  - Write with n mask bits set: ack after n+1 cycles.
- mc_fill_line is not changed by writebacks.

Decomposition:
- Shared include/package mc_defs:
  - MC_PADDR_BITS=26, MC_LINE_BITS=128, MC_WORD_BITS=32, MC_LINE_WORDS=4.
  - State encodings IDLE/BEAT/ACK.
  - next-set-mask-bit function (shared with the cache's writeback path).
- No sub-module; a single FSM plus beat and timeout counters.

Test Plan:
- Read, mem_ready=1, mem preloaded word[0x2000..0x2003]=A0,A1,A2,A3, mc_paddr=0x8000 → mem_addr 0x2000..0x2003 on consecutive cycles; mc_ack 5 cycles after accept; mc_fill_line=0xA3_A2_A1_A0 words; mc_err=0.
- Write mask=4'b1010, paddr=0x40, line words W0..W3 → exactly two beats, addr 0x11 then 0x13 with wdata W1, W3; ack 3 cycles after accept; words 0x10 and 0x12 unchanged.
- Write mask=0 → no mem_en; mc_ack on the next cycle; mc_fill_line unchanged.
- Read with mem_ready low 3 cycles on beat 2 → mem_addr holds 0x..2 for 4 cycles; ack at cycle 8; data correct.
- TIMEOUT=4, mem_ready stuck 0 on beat 1 of a read → abort: mc_ack=mc_err=1 same cycle; fill words 1..3 = 0; next request serviced normally.
- rst_n pulsed low mid-read (beat 2) → all outputs 0 immediately; no ack; the following request (mc_req held) completes correctly.

Source files
------------

// File: rtl/mc_defs_pkg.sv
// ----------------------------------------------------------------
// mc_defs_pkg: shared line/word geometry, responder states, mask walker
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package mc_defs_pkg;

  localparam int MC_PADDR_BITS     = 26;
  localparam int MC_LINE_BITS      = 128;
  localparam int MC_WORD_BITS      = 32;
  localparam int MC_LINE_WORDS     = 4;
  localparam int MC_LINE_ADDR_BITS = MC_PADDR_BITS - 4;
  localparam int MC_MEM_ADDR_BITS  = MC_LINE_ADDR_BITS + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_ACK  = 2'd2
  } mc_state_e;

  typedef logic [MC_LINE_WORDS-1:0][MC_WORD_BITS-1:0] mc_line_t;

  // Lowest set mask bit at or above 'from'; bit 2 of the result flags a hit.
  function automatic logic [2:0] next_mask_bit(input logic [3:0] mask,
                                               input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = MC_LINE_WORDS - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_line_responder.sv
// ----------------------------------------------------------------
// mc_line_responder: serves 128-bit line fills/writebacks as 32-bit beats
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module mc_line_responder
  import mc_defs_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mc_req,
  input  logic                        mc_read,
  input  logic [MC_PADDR_BITS-1:0]    mc_paddr,
  input  logic [MC_LINE_BITS-1:0]     mc_writeback_line,
  input  logic [MC_LINE_WORDS-1:0]    mc_writeback_mask,
  output logic                        mc_ack,
  output logic [MC_LINE_BITS-1:0]     mc_fill_line,
  output logic                        mc_err,
  output logic                        busy,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [MC_MEM_ADDR_BITS-1:0] mem_addr,
  output logic [MC_WORD_BITS-1:0]     mem_wdata,
  input  logic [MC_WORD_BITS-1:0]     mem_rdata,
  input  logic                        mem_ready
);

  localparam int             TCW  = $clog2(TIMEOUT + 2);
  localparam logic [TCW-1:0] TLIM = TCW'(TIMEOUT);

  mc_state_e                     state_q, state_d;
  logic                          read_q, read_d;
  logic [MC_LINE_ADDR_BITS-1:0]  line_q, line_d;
  mc_line_t                      wline_q, wline_d;
  logic [MC_LINE_WORDS-1:0]      mask_q, mask_d;
  logic [1:0]                    beat_q, beat_d;
  logic [TCW-1:0]                tcnt_q, tcnt_d;
  mc_line_t                      shadow_q, shadow_d;
  mc_line_t                      fill_q, fill_d;
  logic                          ack_q, ack_d;
  logic                          err_q, err_d;
  logic                          busy_q, busy_d;
  logic                          en_q, en_d;
  logic                          we_q, we_d;
  logic [MC_MEM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [MC_WORD_BITS-1:0]       wdata_q, wdata_d;
  logic [2:0]                    nxt;

  logic unused_paddr_lsb;
  assign unused_paddr_lsb = ^mc_paddr[3:0];

  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    line_d   = line_q;
    wline_d  = wline_q;
    mask_d   = mask_q;
    beat_d   = beat_q;
    tcnt_d   = tcnt_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;
    nxt      = 3'b000;

    unique case (state_q)
      S_IDLE: begin
        if (mc_req) begin
          read_d  = mc_read;
          line_d  = mc_paddr[MC_PADDR_BITS-1:4];
          wline_d = mc_writeback_line;
          // A read is a write-shaped walk over a full mask.
          mask_d  = mc_read ? '1 : mc_writeback_mask;
          tcnt_d  = '0;
          if (mc_read) shadow_d = '0;
          nxt     = next_mask_bit(mask_d, 3'd0);
          beat_d  = nxt[1:0];
          state_d = nxt[2] ? S_BEAT : S_ACK;
        end
      end
      S_BEAT: begin
        if (mem_ready) begin
          if (read_q) shadow_d[beat_q] = mem_rdata;
          tcnt_d = '0;
          nxt    = next_mask_bit(mask_q, {1'b0, beat_q} + 3'd1);
          if (nxt[2]) beat_d = nxt[1:0];
          else        state_d = S_ACK;
        end else if (TIMEOUT != 0 && (tcnt_q + TCW'(1)) == TLIM) begin
          state_d = S_ACK;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ack_d   = (state_d == S_ACK);
    busy_d  = (state_d != S_IDLE);
    en_d    = (state_d == S_BEAT);
    we_d    = en_d & ~read_d;
    addr_d  = {line_d, beat_d};
    wdata_d = wline_d[beat_d];
    fill_d  = (ack_d && read_d) ? shadow_d : fill_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      read_q   <= 1'b0;
      line_q   <= '0;
      wline_q  <= '0;
      mask_q   <= '0;
      beat_q   <= '0;
      tcnt_q   <= '0;
      shadow_q <= '0;
      fill_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      line_q   <= line_d;
      wline_q  <= wline_d;
      mask_q   <= mask_d;
      beat_q   <= beat_d;
      tcnt_q   <= tcnt_d;
      shadow_q <= shadow_d;
      fill_q   <= fill_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mc_ack       = ack_q;
  assign mc_err       = err_q;
  assign mc_fill_line = fill_q;
  assign busy         = busy_q;
  assign mem_en       = en_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_line_responder.sv
// ----------------------------------------------------------------
// tb_mc_line_responder: transaction-level model and per-cycle compare
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_mc_line_responder;

  localparam int TMO = 4;

  logic         clk;
  logic         rst_n;
  logic         mc_req;
  logic         mc_read;
  logic [25:0]  mc_paddr;
  logic [127:0] mc_writeback_line;
  logic [3:0]   mc_writeback_mask;
  logic         mc_ack;
  logic [127:0] mc_fill_line;
  logic         mc_err;
  logic         busy;
  logic         mem_en;
  logic         mem_we;
  logic [23:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ready;

  mc_line_responder #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mc_req(mc_req), .mc_read(mc_read),
    .mc_paddr(mc_paddr), .mc_writeback_line(mc_writeback_line),
    .mc_writeback_mask(mc_writeback_mask), .mc_ack(mc_ack),
    .mc_fill_line(mc_fill_line), .mc_err(mc_err), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory emulation and the model's own image of it.
  logic [31:0] emu_mem [0:16383];
  logic [31:0] ref_mem [0:16383];

  assign mem_rdata = mem_ready ? emu_mem[mem_addr[13:0]] : 32'hBADC_0FFE;

  always @(posedge clk) begin
    if (rst_n && mem_en && mem_ready && mem_we) emu_mem[mem_addr[13:0]] <= mem_wdata;
  end

  typedef struct {
    bit           busy;
    bit           en;
    bit           we;
    bit           ack;
    bit           err;
    logic [23:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] fill;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e_cur;
  logic [127:0] cur_fill   = '0;
  logic [127:0] model_fill = '0;
  bit           chk_en     = 1'b0;
  int           checks     = 0;
  int           failures   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Single compare process: one expectation per cycle, idle when the queue is empty.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (exp_q.size() > 0) begin
        e_cur = exp_q.pop_front();
      end else begin
        e_cur.busy = 1'b0; e_cur.en = 1'b0; e_cur.we = 1'b0;
        e_cur.ack  = 1'b0; e_cur.err = 1'b0;
        e_cur.addr = '0; e_cur.wdata = '0; e_cur.fill = cur_fill;
      end
      cur_fill = e_cur.fill;
      chk("busy",   128'(busy),   128'(e_cur.busy));
      chk("mem_en", 128'(mem_en), 128'(e_cur.en));
      chk("mc_ack", 128'(mc_ack), 128'(e_cur.ack));
      chk("mc_err", 128'(mc_err), 128'(e_cur.err));
      chk("fill",   mc_fill_line, e_cur.fill);
      if (e_cur.en) begin
        chk("mem_addr", 128'(mem_addr), 128'(e_cur.addr));
        chk("mem_we",   128'(mem_we),   128'(e_cur.we));
        if (e_cur.we) chk("mem_wdata", 128'(mem_wdata), 128'(e_cur.wdata));
      end
    end
  end

  // Builds the expected cycle trace of one request from the line/mask/stall
  // description, drives it, and reports where the ack appeared.
  task automatic txn(input bit skip_wait, input bit rd, input logic [21:0] line,
                     input logic [3:0] mask, input logic [127:0] wl,
                     input logic [3:0][7:0] st, output int ack_at, output int en_cycles);
    exp_t         recs[$];
    bit           rdy[$];
    exp_t         r;
    logic [3:0]   vis;
    logic [127:0] shadow;
    bit           err;
    logic [23:0]  a;
    int           s;
    vis    = rd ? 4'hF : mask;
    shadow = '0;
    err    = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (vis[b] && !err) begin
        a       = {line, 2'(b)};
        s       = int'(st[b]);
        r.busy  = 1'b1; r.en = 1'b1; r.we = !rd; r.ack = 1'b0; r.err = 1'b0;
        r.addr  = a; r.wdata = wl[32*b +: 32]; r.fill = model_fill;
        if (s >= TMO) begin
          repeat (TMO) begin recs.push_back(r); rdy.push_back(1'b0); end
          err = 1'b1;
        end else begin
          repeat (s) begin recs.push_back(r); rdy.push_back(1'b0); end
          recs.push_back(r); rdy.push_back(1'b1);
          if (rd) shadow[32*b +: 32] = ref_mem[a[13:0]];
          else    ref_mem[a[13:0]]   = wl[32*b +: 32];
        end
      end
    end
    r.busy = 1'b1; r.en = 1'b0; r.we = 1'b0; r.ack = 1'b1; r.err = err;
    r.addr = '0; r.wdata = '0; r.fill = rd ? shadow : model_fill;
    recs.push_back(r); rdy.push_back(1'($urandom_range(0, 1)));
    if (rd) model_fill = shadow;

    if (!skip_wait) begin @(negedge clk); #1; end
    mc_req            = 1'b1;
    mc_read           = rd;
    mc_paddr          = {line, 4'($urandom)};
    mc_writeback_line = wl;
    mc_writeback_mask = mask;
    mem_ready         = 1'($urandom_range(0, 1));
    foreach (recs[i]) exp_q.push_back(recs[i]);
    ack_at    = 0;
    en_cycles = 0;
    for (int i = 0; i < recs.size(); i++) begin
      @(negedge clk); #1;
      if (mc_ack && ack_at == 0) ack_at = i + 1;
      if (mem_en) en_cycles++;
      mem_ready = rdy[i];
      if (i == 0) begin
        mc_read           = 1'($urandom_range(0, 1));
        mc_paddr          = 26'($urandom);
        mc_writeback_line = {$urandom, $urandom, $urandom, $urandom};
        mc_writeback_mask = 4'($urandom);
      end
      if (i == recs.size() - 1) mc_req = 1'b0;
    end
  endtask

  localparam logic [127:0] FILL_A = 128'hA00000A3_A00000A2_A00000A1_A00000A0;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int              ack_at;
    int              en_cyc;
    logic [3:0][7:0] st;
    logic [127:0]    wl;

    rst_n = 1'b1; mc_req = 1'b0; mc_read = 1'b0; mc_paddr = '0;
    mc_writeback_line = '0; mc_writeback_mask = '0; mem_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      emu_mem[i] = $urandom; ref_mem[i] = emu_mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      emu_mem[14'h2000 + i] = 32'hA00000A0 + i; ref_mem[14'h2000 + i] = 32'hA00000A0 + i;
      emu_mem[14'h0010 + i] = 32'h55550010 + i; ref_mem[14'h0010 + i] = 32'h55550010 + i;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 128'({mc_ack, mc_err, busy, mem_en, mem_we, mem_addr, mem_wdata}), 128'(0));
    chk("reset_fill", mc_fill_line, 128'(0));
    @(negedge clk); #1;
    rst_n = 1'b1; chk_en = 1'b1;

    // Plain read, no wait states.
    txn(1'b0, 1'b1, 22'h800, 4'h0, 128'(0), '0, ack_at, en_cyc);
    chk("t1_ack_lat", 128'(ack_at), 128'(5));
    chk("t1_fill", mc_fill_line, FILL_A);

    // Sparse writeback 1010.
    wl = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;
    txn(1'b0, 1'b0, 22'h004, 4'b1010, wl, '0, ack_at, en_cyc);
    chk("t2_ack_lat", 128'(ack_at), 128'(3));
    chk("t2_beats", 128'(en_cyc), 128'(2));
    chk("t2_w10", 128'(emu_mem[14'h10]), 128'(32'h55550010));
    chk("t2_w11", 128'(emu_mem[14'h11]), 128'(32'hC0DE0001));
    chk("t2_w12", 128'(emu_mem[14'h12]), 128'(32'h55550012));
    chk("t2_w13", 128'(emu_mem[14'h13]), 128'(32'hC0DE0003));
    chk("t2_fill_kept", mc_fill_line, FILL_A);

    // Empty-mask writeback.
    txn(1'b0, 1'b0, 22'h005, 4'b0000, wl, '0, ack_at, en_cyc);
    chk("t3_ack_lat", 128'(ack_at), 128'(1));
    chk("t3_no_beats", 128'(en_cyc), 128'(0));
    chk("t3_fill_kept", mc_fill_line, FILL_A);

    // Three wait states on beat 2.
    st = '0; st[2] = 8'd3;
    txn(1'b0, 1'b1, 22'h800, 4'h0, 128'(0), st, ack_at, en_cyc);
    chk("t4_ack_lat", 128'(ack_at), 128'(8));
    chk("t4_fill", mc_fill_line, FILL_A);

    // Beat 1 never becomes ready: abort.
    st = '0; st[1] = 8'd7;
    txn(1'b0, 1'b1, 22'h800, 4'h0, 128'(0), st, ack_at, en_cyc);
    chk("t5_ack_lat", 128'(ack_at), 128'(6));
    chk("t5_fill", mc_fill_line, 128'h00000000_00000000_00000000_A00000A0);
    txn(1'b0, 1'b1, 22'h800, 4'h0, 128'(0), '0, ack_at, en_cyc);
    chk("t5_recover", mc_fill_line, FILL_A);

    // Reset in the middle of beat 2, request held across it.
    @(negedge clk); #1;
    chk_en = 1'b0; mc_req = 1'b1; mc_read = 1'b1; mc_paddr = 26'h0008000; mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t6_addr", 128'({mem_en, mem_addr}), 128'({1'b1, 24'h002000 + 24'(k)}));
    end
    rst_n = 1'b0; #1;
    chk("t6_rst_outs", 128'({mc_ack, mc_err, busy, mem_en, mem_we, mem_addr, mem_wdata}), 128'(0));
    chk("t6_rst_fill", mc_fill_line, 128'(0));
    exp_q.delete(); model_fill = '0; cur_fill = '0;
    ack_at = 0;
    repeat (2) begin @(negedge clk); if (mc_ack) ack_at = 1; end
    chk("t6_no_ack", 128'(ack_at), 128'(0));
    #1; rst_n = 1'b1; chk_en = 1'b1;
    txn(1'b1, 1'b1, 22'h800, 4'h0, 128'(0), '0, ack_at, en_cyc);
    chk("t6_ack_lat", 128'(ack_at), 128'(5));
    chk("t6_fill", mc_fill_line, FILL_A);

    // Randomized traffic over 16 lines with occasional timeouts.
    for (int n = 0; n < 200; n++) begin
      for (int b = 0; b < 4; b++)
        st[b] = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(4, 6)) : 8'($urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      txn(1'b0, 1'($urandom_range(0, 1)), 22'($urandom_range(0, 15)), 4'($urandom),
          {$urandom, $urandom, $urandom, $urandom}, st, ack_at, en_cyc);
    end
    @(negedge clk); @(negedge clk);

    for (int i = 0; i < 64; i++) chk("mem_image", 128'(emu_mem[i]), 128'(ref_mem[i]));
    for (int i = 0; i < 4; i++)
      chk("mem_image_hi", 128'(emu_mem[14'h2000 + i]), 128'(ref_mem[14'h2000 + i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
